// File: rtl/duck_pkg.sv
// Shared definitions for the duck-hunt cursor/trigger path.
//   trig_state_t     : trigger FSM encoding, also driven out on trig_state
//   POS_W            : width of an absolute screen coordinate
//   SCREEN_*         : playfield bounds and center, shared with the cursor block
package duck_pkg;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        COOLDOWN = 2'd1,
        EMPTY    = 2'd2
    } trig_state_t;

    localparam int POS_W = 10;

    localparam int SCREEN_X_MIN    = 10;
    localparam int SCREEN_X_MAX    = 629;
    localparam int SCREEN_Y_MIN    = 10;
    localparam int SCREEN_Y_MAX    = 399;
    localparam int SCREEN_X_CENTER = 320;
    localparam int SCREEN_Y_CENTER = 240;

endpackage

// File: rtl/mouse_tracker_if.sv
// Relative mouse report channel (valid/ready handshake).
//   report_valid   : report present (master -> slave)
//   report_ready   : slave can accept a report (slave -> master)
//   report_dx/dy   : signed deltas, dy positive means down
//   report_buttons : bit0 left, bit1 right, bit2 middle
interface mouse_tracker_if;

    logic       report_valid;
    logic       report_ready;
    logic [7:0] report_dx;
    logic [7:0] report_dy;
    logic [7:0] report_buttons;

    modport master (
        output report_valid,
        output report_dx,
        output report_dy,
        output report_buttons,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_dx,
        input  report_dy,
        input  report_buttons,
        output report_ready
    );

endinterface

// File: rtl/mouse_tracker_axis_accum.sv
// One screen axis: accumulates signed deltas into an absolute position,
// saturating to [MIN, MAX], with a recenter override.
//   frame_clk, Reset : clock, asynchronous active-high reset (pos -> CENTER)
//   accept           : apply delta this cycle
//   recenter         : jump to CENTER (wins over accept)
//   delta            : signed 8-bit movement
//   pos              : current absolute position
module axis_accum
    import duck_pkg::*;
#(
    parameter int MIN         = SCREEN_X_MIN,
    parameter int MAX         = SCREEN_X_MAX,
    parameter int CENTER      = SCREEN_X_CENTER,
    parameter int SPEED_SHIFT = 0
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              accept,
    input  logic              recenter,
    input  logic signed [7:0] delta,
    output logic [POS_W-1:0]  pos
);

    // 13 bits holds 1023 + (127 << 3) and -(128 << 3) without overflow.
    localparam int SUM_W = 13;

    logic        [POS_W-1:0] pos_q, pos_d;
    logic signed [SUM_W-1:0] step_s;
    logic signed [SUM_W-1:0] sum_s;

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] v);
        if (v < $signed(SUM_W'(MIN))) begin
            return POS_W'(MIN);
        end
        if (v > $signed(SUM_W'(MAX))) begin
            return POS_W'(MAX);
        end
        return v[POS_W-1:0];
    endfunction

    always_comb begin
        step_s = SUM_W'(delta) <<< SPEED_SHIFT;
        sum_s  = $signed({{(SUM_W-POS_W){1'b0}}, pos_q}) + step_s;
        pos_d  = pos_q;
        if (recenter) begin
            pos_d = POS_W'(CENTER);
        end else if (accept) begin
            pos_d = clamp_pos(sum_s);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            pos_q <= POS_W'(CENTER);
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/mouse_tracker.sv
// Converts relative mouse reports into absolute cursor coordinates and runs
// the trigger: left-click edge detection, shot cooldown and shell count.
//   Reset, frame_clk : asynchronous active-high reset, frame clock
//   rpt              : report channel (slave side), ready = !freeze
//   freeze           : hold position, refuse reports, block trigger
//   recenter         : jump to center (wins over an accepted report)
//   reload           : refill shells; leaves EMPTY for READY
//   mouseX/mouseY    : absolute position, zero-extended
//   mouseButton      : last accepted button byte
//   shot             : one-cycle pulse per fired shot
//   shells_left      : remaining shells
//   trig_state       : 0 READY, 1 COOLDOWN, 2 EMPTY
module mouse_tracker #(
    parameter int X_CENTER    = duck_pkg::SCREEN_X_CENTER,
    parameter int Y_CENTER    = duck_pkg::SCREEN_Y_CENTER,
    parameter int X_MIN       = duck_pkg::SCREEN_X_MIN,
    parameter int X_MAX       = duck_pkg::SCREEN_X_MAX,
    parameter int Y_MIN       = duck_pkg::SCREEN_Y_MIN,
    parameter int Y_MAX       = duck_pkg::SCREEN_Y_MAX,
    parameter int SPEED_SHIFT = 0,
    parameter int SHELLS      = 3,
    parameter int COOLDOWN    = 8
) (
    input  logic                  Reset,
    input  logic                  frame_clk,
    mouse_tracker_if.slave        rpt,
    input  logic                  freeze,
    input  logic                  recenter,
    input  logic                  reload,
    output logic [31:0]           mouseX,
    output logic [31:0]           mouseY,
    output logic [7:0]            mouseButton,
    output logic                  shot,
    output logic [1:0]            shells_left,
    output logic [1:0]            trig_state
);

    localparam int          CNT_W      = $clog2(COOLDOWN + 1);
    localparam logic [1:0]  SHELLS_MAX = 2'(SHELLS);

    logic                       accept;
    logic                       left_rise;
    logic [duck_pkg::POS_W-1:0] x_pos, y_pos;

    logic [7:0]                 btn_q, btn_d;
    logic                       prev_left_q, prev_left_d;
    duck_pkg::trig_state_t      state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [1:0]                 shells_q, shells_d;
    logic                       shot_q, shot_d;
    logic [1:0]                 shells_base;

    // Ready drops while Reset is held as well, since Reset is asynchronous.
    assign rpt.report_ready = !freeze && !Reset;
    assign accept           = rpt.report_valid && rpt.report_ready;
    assign left_rise        = accept && rpt.report_buttons[0] && !prev_left_q;

    axis_accum #(
        .MIN(X_MIN), .MAX(X_MAX), .CENTER(X_CENTER), .SPEED_SHIFT(SPEED_SHIFT)
    ) u_x (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .accept   (accept),
        .recenter (recenter),
        .delta    ($signed(rpt.report_dx)),
        .pos      (x_pos)
    );

    axis_accum #(
        .MIN(Y_MIN), .MAX(Y_MAX), .CENTER(Y_CENTER), .SPEED_SHIFT(SPEED_SHIFT)
    ) u_y (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .accept   (accept),
        .recenter (recenter),
        .delta    ($signed(rpt.report_dy)),
        .pos      (y_pos)
    );

    // Button byte and the left-button history only move on acceptance, so a
    // held button across refused/idle cycles never looks like a new press.
    always_comb begin
        btn_d       = btn_q;
        prev_left_d = prev_left_q;
        if (accept) begin
            btn_d       = rpt.report_buttons;
            prev_left_d = rpt.report_buttons[0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shells_d    = shells_q;
        shot_d      = 1'b0;
        // A same-cycle reload refills before the shot is taken.
        shells_base = reload ? SHELLS_MAX : shells_q;
        unique case (state_q)
            duck_pkg::READY: begin
                if (left_rise && !freeze && shells_q != 2'd0) begin
                    shot_d   = 1'b1;
                    shells_d = shells_base - 2'd1;
                    cnt_d    = CNT_W'(COOLDOWN - 1);
                    state_d  = (shells_base == 2'd1) ? duck_pkg::EMPTY
                                                     : duck_pkg::COOLDOWN;
                end else if (reload) begin
                    shells_d = SHELLS_MAX;
                end
            end
            duck_pkg::COOLDOWN: begin
                // Presses here are dropped; the counter ignores freeze.
                if (reload) begin
                    shells_d = SHELLS_MAX;
                end
                if (cnt_q == '0) begin
                    state_d = duck_pkg::READY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            duck_pkg::EMPTY: begin
                if (reload) begin
                    shells_d = SHELLS_MAX;
                    state_d  = duck_pkg::READY;
                end
            end
            default: begin
                state_d = duck_pkg::READY;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            btn_q       <= 8'd0;
            prev_left_q <= 1'b0;
            state_q     <= duck_pkg::READY;
            cnt_q       <= '0;
            shells_q    <= SHELLS_MAX;
            shot_q      <= 1'b0;
        end else begin
            btn_q       <= btn_d;
            prev_left_q <= prev_left_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shells_q    <= shells_d;
            shot_q      <= shot_d;
        end
    end

    assign mouseX      = 32'(x_pos);
    assign mouseY      = 32'(y_pos);
    assign mouseButton = btn_q;
    assign shot        = shot_q;
    assign shells_left = shells_q;
    assign trig_state  = state_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Bench for mouse_tracker: directed vector table, hand-written reset
// sequences and randomized traffic against a behavioural model.
module tb_mouse_tracker;

    localparam int X_CENTER = 320, Y_CENTER = 240;
    localparam int X_MIN = 10, X_MAX = 629, Y_MIN = 10, Y_MAX = 399;
    localparam int SPEED_SHIFT = 0;
    localparam int SHELLS = 3;
    localparam int COOLDOWN = 8;

    logic        Reset;
    logic        frame_clk;
    logic        freeze, recenter, reload;
    logic [31:0] mouseX, mouseY;
    logic [7:0]  mouseButton;
    logic        shot;
    logic [1:0]  shells_left, trig_state;

    mouse_tracker_if rif ();

    mouse_tracker #(
        .X_CENTER(X_CENTER), .Y_CENTER(Y_CENTER),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .SPEED_SHIFT(SPEED_SHIFT), .SHELLS(SHELLS), .COOLDOWN(COOLDOWN)
    ) dut (
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .rpt        (rif.slave),
        .freeze     (freeze),
        .recenter   (recenter),
        .reload     (reload),
        .mouseX     (mouseX),
        .mouseY     (mouseY),
        .mouseButton(mouseButton),
        .shot       (shot),
        .shells_left(shells_left),
        .trig_state (trig_state)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Trigger availability is tracked as "the edge number up to which the
    // trigger is blocked" rather than as a down-counter.
    int       m_x, m_y, m_btn, m_shot, m_shells;
    bit       m_prev, m_empty;
    int       edge_n;
    int       blocked_until;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int sx8(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    task automatic model_reset();
        m_x = X_CENTER; m_y = Y_CENTER; m_btn = 0; m_shot = 0;
        m_shells = SHELLS; m_prev = 0; m_empty = 0;
        blocked_until = edge_n;
    endtask

    task automatic model_edge(input bit fr, input bit rc, input bit rl, input bit v,
                              input logic [7:0] dx, input logic [7:0] dy,
                              input logic [7:0] btn);
        bit acc, rise, fire;
        edge_n++;
        acc  = v && !fr;
        rise = acc && btn[0] && !m_prev;
        fire = rise && !m_empty && (edge_n > blocked_until) && (m_shells > 0);
        if (rc) begin
            m_x = X_CENTER; m_y = Y_CENTER;
        end else if (acc) begin
            m_x = clampi(m_x + sx8(dx) * (1 << SPEED_SHIFT), X_MIN, X_MAX);
            m_y = clampi(m_y + sx8(dy) * (1 << SPEED_SHIFT), Y_MIN, Y_MAX);
        end
        if (acc) begin
            m_btn  = int'(btn);
            m_prev = btn[0];
        end
        m_shot = fire ? 1 : 0;
        if (fire) begin
            m_shells = (rl ? SHELLS : m_shells) - 1;
            blocked_until = edge_n + COOLDOWN;
            if (m_shells == 0) m_empty = 1;
        end else if (rl) begin
            m_shells = SHELLS;
            if (m_empty) begin
                m_empty = 0;
                blocked_until = edge_n;
            end
        end
    endtask

    function automatic int model_state();
        if (m_empty) return 2;
        return (edge_n < blocked_until) ? 1 : 0;
    endfunction

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit fr, input bit rc, input bit rl, input bit v,
                        input logic [7:0] dx, input logic [7:0] dy,
                        input logic [7:0] btn);
        freeze = fr; recenter = rc; reload = rl;
        rif.report_valid = v; rif.report_dx = dx; rif.report_dy = dy;
        rif.report_buttons = btn;
        model_edge(fr, rc, rl, v, dx, dy, btn);
        @(posedge frame_clk);
        #1;
        chk("model_x",      int'(mouseX),       m_x);
        chk("model_y",      int'(mouseY),       m_y);
        chk("model_button", int'(mouseButton),  m_btn);
        chk("model_shot",   int'(shot),         m_shot);
        chk("model_shells", int'(shells_left),  m_shells);
        chk("model_state",  int'(trig_state),   model_state());
        chk("model_ready",  int'(rif.report_ready), fr ? 0 : 1);
        recenter = 1'b0; reload = 1'b0;
    endtask

    task automatic idle_inputs();
        freeze = 0; recenter = 0; reload = 0;
        rif.report_valid = 0; rif.report_dx = 0; rif.report_dy = 0;
        rif.report_buttons = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"},      int'(mouseX),      X_CENTER);
        chk({tag, "_y"},      int'(mouseY),      Y_CENTER);
        chk({tag, "_button"}, int'(mouseButton), 0);
        chk({tag, "_shot"},   int'(shot),        0);
        chk({tag, "_shells"}, int'(shells_left), SHELLS);
        chk({tag, "_state"},  int'(trig_state),  0);
        chk({tag, "_ready"},  int'(rif.report_ready), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         fr, rc, rl, v;
        logic [7:0] dx, dy, btn;
        int         ex, ey, eb, eshot, eshells, est;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit fr, input bit rc, input bit rl, input bit v,
                                input logic [7:0] dx, input logic [7:0] dy,
                                input logic [7:0] btn,
                                input int ex, input int ey, input int eb,
                                input int eshot, input int eshells, input int est);
        vec_t e;
        e.fr = fr; e.rc = rc; e.rl = rl; e.v = v;
        e.dx = dx; e.dy = dy; e.btn = btn;
        e.ex = ex; e.ey = ey; e.eb = eb;
        e.eshot = eshot; e.eshells = eshells; e.est = est;
        tbl.push_back(e);
    endfunction

    function automatic void fill_table();
        int xs[8] = '{501, 373, 245, 117, 10, 10, 10, 10};
        int ys[8] = '{271, 143, 15, 10, 10, 10, 10, 10};
        // movement and clamping
        add(0,0,0,1, 8'd5,   8'hFD, 8'd0, 325, 237, 0, 0, 3, 0);
        add(0,0,0,1, 8'd127, 8'd127, 8'd0, 452, 364, 0, 0, 3, 0);
        add(0,0,0,1, 8'd127, 8'd127, 8'd0, 579, 399, 0, 0, 3, 0);
        add(0,0,0,1, 8'd41,  8'd0,  8'd0, 620, 399, 0, 0, 3, 0);
        add(0,0,0,1, 8'd127, 8'd0,  8'd0, 629, 399, 0, 0, 3, 0);
        for (int i = 0; i < 8; i++)
            add(0,0,0,1, 8'h80, 8'h80, 8'd0, xs[i], ys[i], 0, 0, 3, 0);
        // first shot, held button, cooldown of 8 frames
        add(0,0,0,1, 8'd0, 8'd0, 8'd1, 10, 10, 1, 1, 2, 1);
        add(0,0,0,1, 8'd0, 8'd0, 8'd1, 10, 10, 1, 0, 2, 1);
        for (int i = 0; i < 6; i++)
            add(0,0,0,0, 8'd0, 8'd0, 8'd0, 10, 10, 1, 0, 2, 1);
        add(0,0,0,0, 8'd0, 8'd0, 8'd0, 10, 10, 1, 0, 2, 0);
        // second shot, then freeze during cooldown
        add(0,0,0,1, 8'd0, 8'd0, 8'd0, 10, 10, 0, 0, 2, 0);
        add(0,0,0,1, 8'd0, 8'd0, 8'd1, 10, 10, 1, 1, 1, 1);
        add(1,0,0,1, 8'd50, 8'd50, 8'd0, 10, 10, 1, 0, 1, 1);
        add(1,1,0,0, 8'd0, 8'd0, 8'd0, 320, 240, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++)
            add(0,0,0,0, 8'd0, 8'd0, 8'd0, 320, 240, 1, 0, 1, 1);
        add(0,0,0,0, 8'd0, 8'd0, 8'd0, 320, 240, 1, 0, 1, 0);
        // third shot empties, press while empty, reload paths
        add(0,0,0,1, 8'd0, 8'd0, 8'd0, 320, 240, 0, 0, 1, 0);
        add(0,0,0,1, 8'd0, 8'd0, 8'd1, 320, 240, 1, 1, 0, 2);
        add(0,0,0,1, 8'd0, 8'd0, 8'd0, 320, 240, 0, 0, 0, 2);
        add(0,0,0,1, 8'd0, 8'd0, 8'd1, 320, 240, 1, 0, 0, 2);
        add(0,0,0,1, 8'd0, 8'd0, 8'd0, 320, 240, 0, 0, 0, 2);
        add(0,0,1,1, 8'd0, 8'd0, 8'd1, 320, 240, 1, 0, 3, 0);
        add(0,0,0,1, 8'd0, 8'd0, 8'd0, 320, 240, 0, 0, 3, 0);
        add(0,0,1,1, 8'd0, 8'd0, 8'd1, 320, 240, 1, 1, 2, 1);
        // recenter beats an accepted report; buttons still taken
        add(0,1,0,1, 8'd5, 8'd5, 8'd6, 320, 240, 6, 0, 2, 1);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        edge_n = 0;
        idle_inputs();
        Reset = 1'b1;
        model_reset();
        #3;
        check_reset_values("reset");
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();

        fill_table();
        foreach (tbl[i]) begin
            step(tbl[i].fr, tbl[i].rc, tbl[i].rl, tbl[i].v,
                 tbl[i].dx, tbl[i].dy, tbl[i].btn);
            chk($sformatf("vec%0d_x", i),      int'(mouseX),      tbl[i].ex);
            chk($sformatf("vec%0d_y", i),      int'(mouseY),      tbl[i].ey);
            chk($sformatf("vec%0d_button", i), int'(mouseButton), tbl[i].eb);
            chk($sformatf("vec%0d_shot", i),   int'(shot),        tbl[i].eshot);
            chk($sformatf("vec%0d_shells", i), int'(shells_left), tbl[i].eshells);
            chk($sformatf("vec%0d_state", i),  int'(trig_state),  tbl[i].est);
        end

        // Still in cooldown: walk to (100,50), then async reset mid-cycle.
        step(0,0,0,1, 8'h80, 8'h80, 8'd0);
        step(0,0,0,1, 8'hA4, 8'hC2, 8'd0);
        chk("pre_reset_x", int'(mouseX), 100);
        chk("pre_reset_y", int'(mouseY), 50);
        chk("pre_reset_state", int'(trig_state), 1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        idle_inputs();
        model_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit         fr, rc, rl, v;
            logic [7:0] dx, dy, btn;
            fr  = ($urandom_range(0, 9) == 0);
            rc  = ($urandom_range(0, 39) == 0);
            rl  = ($urandom_range(0, 24) == 0);
            v   = ($urandom_range(0, 9) < 7);
            dx  = 8'($urandom);
            dy  = 8'($urandom);
            btn = 8'($urandom);
            if ($urandom_range(0, 2) != 0) btn[0] = m_prev;
            step(fr, rc, rl, v, dx, dy, btn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
